// File: rtl/param_serial_twos_complement_pkg.sv
// Shared definitions for the bit-serial two's-complement unit:
// mode codes, FSM state encoding and the negate-decision helper.
package param_serial_twos_complement_pkg;

    localparam logic [1:0] MODE_PASS = 2'b00;
    localparam logic [1:0] MODE_NEG  = 2'b01;
    localparam logic [1:0] MODE_ABS  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    // Decide once, at accept time, whether this operand gets negated.
    // The reserved code 2'b11 behaves like pass.
    function automatic logic resolve_neg(input logic [1:0] mode, input logic msb);
        logic neg;
        case (mode)
            MODE_PASS: neg = 1'b0;
            MODE_NEG:  neg = 1'b1;
            MODE_ABS:  neg = msb;
            default:   neg = 1'b0;
        endcase
        return neg;
    endfunction

endpackage

// File: rtl/param_serial_twos_complement_full_adder.sv
// One-bit full adder used as the single serial arithmetic stage.
module param_serial_twos_complement_full_adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic s,
    output logic c_out
);

    assign s     = a ^ b ^ c_in;
    assign c_out = (a & b) | (a & c_in) | (b & c_in);

endmodule

// File: rtl/param_serial_twos_complement.sv
// Bit-serial two's-complement unit: pass, negate (~X+1) or absolute value,
// one bit per clock, LSB first, through one full adder and a carry flop.
//
// Handshake: an operand transfers on a rising edge where in_valid && in_ready;
// in_ready is high only in IDLE. A result transfers on a rising edge where
// out_valid && out_ready; out_valid is high only in DONE, and Y/flags hold
// there until that transfer happens.
module param_serial_twos_complement #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] X,
    input  logic [1:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Y,
    output logic             c_out,
    output logic             overflow,
    output logic             zero
);

    import param_serial_twos_complement_pkg::*;

    localparam int                CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0]  MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] x_sr;
    logic [WIDTH-1:0] y_sr;
    logic [CNT_W-1:0] cnt;
    logic             do_neg;
    logic             carry;
    logic             ovf_q;
    logic             accept;
    logic             load_neg;
    logic             fa_s;
    logic             fa_c;

    assign accept   = in_valid & (state == ST_IDLE);
    assign load_neg = resolve_neg(sel, X[WIDTH-1]);

    // Single serial stage: the second addend is always zero, so the
    // carry flop alone supplies the "+1" of a negation.
    param_serial_twos_complement_full_adder u_fa (
        .a     (x_sr[0] ^ do_neg),
        .b     (1'b0),
        .c_in  (carry),
        .s     (fa_s),
        .c_out (fa_c)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: IDLE -> SHIFT on accept, SHIFT -> DONE after the
    // last bit, DONE -> IDLE when the result is taken.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (accept)          state_next = ST_SHIFT;
            ST_SHIFT: if (cnt == LAST_CNT) state_next = ST_DONE;
            ST_DONE:  if (out_ready)       state_next = ST_IDLE;
            default:                       state_next = ST_IDLE;
        endcase
    end

    // Datapath: load the operand on accept, then shift one bit per cycle;
    // everything holds outside SHIFT so DONE presents a stable result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_sr   <= '0;
            y_sr   <= '0;
            cnt    <= '0;
            do_neg <= 1'b0;
            carry  <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (accept) begin
            x_sr   <= X;
            cnt    <= '0;
            do_neg <= load_neg;
            carry  <= load_neg;
            ovf_q  <= load_neg & (X == MOST_NEG);
        end else if (state == ST_SHIFT) begin
            y_sr  <= {fa_s, y_sr[WIDTH-1:1]};
            x_sr  <= x_sr >> 1;
            carry <= fa_c;
            if (cnt != LAST_CNT) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign Y         = y_sr;
    assign c_out     = carry;
    assign overflow  = ovf_q;
    assign zero      = (state == ST_DONE) && (y_sr == '0);

endmodule

// File: tb/tb_param_serial_twos_complement.sv
// Bench for the bit-serial two's-complement unit (WIDTH=6): directed
// cases, back-pressure, mid-operation reset and a randomized run
// scored against an arithmetic reference model.
module tb_param_serial_twos_complement;

  localparam int W = 6;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x;
  logic [1:0]   sel;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] y;
  logic         c_out;
  logic         overflow;
  logic         zero;

  int checks   = 0;
  int failures = 0;

  // Expected results packed as {y, c_out, overflow, zero}.
  logic [W+2:0] exp_q[$];

  param_serial_twos_complement #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .X         (x),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Y         (y),
    .c_out     (c_out),
    .overflow  (overflow),
    .zero      (zero)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: arithmetic on integers modulo 2^W.
  function automatic logic [W+2:0] model(input logic [W-1:0] xv, input logic [1:0] s);
    int unsigned  xi;
    int unsigned  yi;
    bit           neg;
    bit           c;
    bit           ovf;
    logic [W-1:0] yv;
    xi  = xv;
    neg = (s == 2'd1) || (s == 2'd2 && xi >= (2 ** (W - 1)));
    if (neg) begin
      yi = ((2 ** W) - xi) % (2 ** W);
      c  = (xi == 0);
    end else begin
      yi = xi;
      c  = 1'b0;
    end
    ovf = neg && (xi == (2 ** (W - 1)));
    yv  = W'(yi);
    return {yv, c, ovf, (yi == 0)};
  endfunction

  task automatic check_result(input string tag, input logic [W+2:0] e);
    check_eq({tag, "_y"},        32'(y),        32'(e[W+2:3]));
    check_eq({tag, "_c_out"},    32'(c_out),    32'(e[2]));
    check_eq({tag, "_overflow"}, 32'(overflow), 32'(e[1]));
    check_eq({tag, "_zero"},     32'(zero),     32'(e[0]));
  endtask

  // Driver: present one operand, then verify latency, result, optional
  // back-pressure hold for `stall` cycles, and return to IDLE.
  task automatic run_op(input logic [W-1:0] xv, input logic [1:0] s, input int stall);
    logic [W+2:0] e;
    int           n;
    int           waitc;
    waitc = 0;
    while (!in_ready && waitc < 20) begin
      @(posedge clk); #1;
      waitc++;
    end
    check_eq("in_ready_idle", 32'(in_ready), 32'd1);
    exp_q.push_back(model(xv, s));
    x         = xv;
    sel       = s;
    in_valid  = 1'b1;
    out_ready = (stall == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    x        = W'($urandom);
    sel      = 2'($urandom);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!out_valid && n < 3 * W);
    check_eq("latency", 32'(n), 32'(W));
    e = exp_q.pop_front();
    check_result("result", e);
    for (int i = 0; i < stall; i++) begin
      in_valid = (i == 0);
      x        = W'($urandom);
      sel      = 2'($urandom);
      @(posedge clk); #1;
      check_result("hold", e);
      check_eq("hold_out_valid", 32'(out_valid), 32'd1);
      check_eq("hold_in_ready",  32'(in_ready),  32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("release_out_valid", 32'(out_valid), 32'd0);
    check_eq("release_in_ready",  32'(in_ready),  32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    x         = '0;
    sel       = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_in_ready",  32'(in_ready),  32'd1);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_y",         32'(y),         32'd0);
    check_eq("rst_c_out",     32'(c_out),     32'd0);
    check_eq("rst_overflow",  32'(overflow),  32'd0);
    check_eq("rst_zero",      32'(zero),      32'd0);
    rst_n = 1'b1;

    // T1: negate 5 -> 111011, also a hand-derived check of the model.
    check_eq("t1_model", 32'(model(6'b000101, 2'b01)), 32'({6'b111011, 1'b0, 1'b0, 1'b0}));
    run_op(6'b000101, 2'b01, 0);
    // T2: most-negative value wraps with overflow, both modes.
    run_op(6'b100000, 2'b01, 0);
    run_op(6'b100000, 2'b10, 0);
    // T3: abs of -7 and of +7.
    run_op(6'b111001, 2'b10, 0);
    run_op(6'b000111, 2'b10, 0);
    // T4: negate zero; pass and reserved code.
    check_eq("t4_model", 32'(model(6'b000000, 2'b01)), 32'({6'b000000, 1'b1, 1'b0, 1'b1}));
    run_op(6'b000000, 2'b01, 0);
    run_op(6'b101010, 2'b00, 0);
    run_op(6'b101010, 2'b11, 0);
    // T5: back-pressure for 3 cycles with an in_valid pulse.
    run_op(6'b010011, 2'b01, 3);

    // T6: reset on the third SHIFT cycle discards the operand.
    x         = 6'b001100;
    sel       = 2'b01;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("t6_out_valid", 32'(out_valid), 32'd0);
    check_eq("t6_y",         32'(y),         32'd0);
    check_eq("t6_in_ready",  32'(in_ready),  32'd1);
    check_eq("t6_c_out",     32'(c_out),     32'd0);
    check_eq("t6_overflow",  32'(overflow),  32'd0);
    #1;
    rst_n = 1'b1;
    run_op(6'b110110, 2'b10, 0);

    // Randomized run with random back-pressure.
    for (int k = 0; k < 40; k++) begin
      run_op(W'($urandom), 2'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
